alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer for the shared n-bit ALU. It accepts operation requests from two clients over a req/ack/done handshake and grants them round-robin. It drives the ALU's operand, control and flag-in inputs from registered copies of the winning request, then captures the ALU's result and flags into output registers. The ALU itself stays combinational and outside this block; this block owns every ALU input.

## Interface

- N, default 4: datapath width; must match the ALU's `n`.

Clock and reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0 / req1  input  1  request from client 0 / client 1
- a0, b0 / a1, b1  input  N  operands of client 0 / client 1
- op0 / op1  input  4  ALU opcode, 0..9 valid
- fin0 / fin1  input  1  ALU flag-in
- ack0 / ack1  output  1  one-cycle pulse: request accepted
- done0 / done1  output  1  one-cycle pulse: result valid
- result  output  N  captured ALU result
- flags  output  2  captured flags; [1] = Z, [0] = C
- err  output  1  set with done when the opcode was invalid
- busy  output  1  high whenever state ≠ IDLE
- alu_a, alu_b  output  N  to ALUA / ALUB
- alu_ctrl  output  4  to ALUControl
- alu_fin  output  1  to ALUFlagIn
- alu_res  input  N  from ALUResult
- alu_flags  input  2  from ALUFlags

## Operation

- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that client.
  - If both are high, grant the client that is not `last` (`last` = most recent grantee).
  - On grant: latch that client's a, b, op and fin into the alu_* registers; set `gnt` and `last` to the winner; go to EXEC.
- EXEC:
  - ack[gnt] = 1.
  - The ALU evaluates the latched inputs.
  - At the end of the cycle, capture into result / flags / err, then go to DONE.
- DONE:
  - done[gnt] = 1; result, flags and err are valid.
  - Go to IDLE. DONE never grants.
- Capture rules:
  - Valid op (0..9): result = alu_res; flags[1] = alu_flags[1]; flags[0] = alu_flags[0] only for op 8/9 (shifts), else 0. The ALU's C is not driven for non-shift ops and must be masked.
  - Invalid op (10..15): result = 0, flags = 2'b10, err = 1. The ALU is still driven, but its outputs are ignored.
- Holding rules:
  - result, flags and err hold until the next capture.
  - alu_* outputs hold the last latched request outside EXEC.
- A client must hold req and its operands stable until it sees its ack. After ack it may drop req or change operands; the latched copy is used.
- A req still high in the DONE cycle is treated as a new request in the following IDLE.
- req from the client currently in EXEC/DONE is not queued; it is sampled only in IDLE.

## Timing

- Reset values: state = IDLE, last = 1 (client 0 wins the first tie), gnt = 0. ack0, ack1, done0, done1, busy, err = 0. result = 0, flags = 0, alu_a = alu_b = 0, alu_ctrl = 0, alu_fin = 0.
- Latency, with req sampled high in IDLE at edge k:
  - ack during cycle k+1 (EXEC);
  - done and valid result during cycle k+2 (DONE);
  - IDLE again at k+3.
- Throughput: one operation per 3 cycles. Two continuously requesting clients alternate 0, 1, 0, 1, …
- All outputs are registered or decoded from registered state; there is no combinational path from req to ack/done.
- Reset in EXEC or DONE aborts the operation:
  - no done is issued for it;
  - outputs take their reset values on the next cycle;
  - the round-robin pointer is reset.

## Test plan

- Single op: after reset, req0 with op=2 (suma), a0=3, b0=5, fin0=1 → ack0 one cycle later, then done0; result=4'b1001, flags=2'b00, err=0; client 1 sees no pulses.
- Simultaneous requests: req0 and req1 both held high from reset → grants in order 0, 1, 0, 1; each done lands 2 cycles after its grant edge; no cycle has both ack0 and ack1 high.
- Shift carry: req1 with op=8, a1=4'b1001, b1=1, fin1=0 → result=4'b0010, flags=2'b01. Then op=9, a=4'b0001, b=1, fin=1 → result=4'b1000, flags=2'b01.
- Zero and C masking: op=6 (resta), a=2, b=2, fin=0, issued right after a shift that set C → result=0, flags=2'b10.
- Invalid opcode: op=12 → done pulse with err=1, result=0, flags=2'b10. The next valid op clears err.
- Reset mid-operation: assert rst for one cycle during EXEC → no done pulse; busy, result and flags = 0; the next tie is granted to client 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer that owns the shared ALU's inputs
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [3:0]   op0,
    input  logic [3:0]   op1,
    input  logic         fin0,
    input  logic         fin1,
    output logic         ack0,
    output logic         ack1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] result,
    output logic [1:0]   flags,
    output logic         err,
    output logic         busy,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    output logic         alu_fin,
    input  logic [N-1:0] alu_res,
    input  logic [1:0]   alu_flags
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;
    logic last, gnt, pick, grant, valid, shift;

    // State register; reset always lands in IDLE, aborting any operation in flight
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    // Grant decision and next state: ties go to the client that was not granted last
    always_comb begin
        pick = (req0 && req1) ? ~last : req1;
        grant = (state == IDLE) && (req0 || req1);
        state_nxt = grant ? EXEC : (state == EXEC) ? DONE : IDLE;
    end

    assign valid = alu_ctrl <= 4'd9;
    assign shift = valid && alu_ctrl[3];

    // Latch the winner's request into the ALU inputs; capture ALU outputs at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 1'b1;
            gnt      <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            alu_fin  <= 1'b0;
            result   <= '0;
            flags    <= '0;
            err      <= 1'b0;
        end else begin
            if (grant) begin
                gnt      <= pick;
                last     <= pick;
                alu_a    <= pick ? a1 : a0;
                alu_b    <= pick ? b1 : b0;
                alu_ctrl <= pick ? op1 : op0;
                alu_fin  <= pick ? fin1 : fin0;
            end
            if (state == EXEC) begin
                result <= valid ? alu_res : '0;
                flags  <= valid ? {alu_flags[1], shift & alu_flags[0]} : 2'b10;
                err    <= ~valid;
            end
        end
    end

    assign ack0  = (state == EXEC) && !gnt;
    assign ack1  = (state == EXEC) && gnt;
    assign done0 = (state == DONE) && !gnt;
    assign done1 = (state == DONE) && gnt;
    assign busy  = state != IDLE;
endmodule
